fft32_input_loader: RTL

- Front end of the 32-point, 32-bit FFT datapath. Accepts one time-domain sample per cycle over a valid/ready stream.
- Writes each sample into a ping-pong frame buffer at its 5-bit bit-reversed lane, then presents a full 32-lane parallel frame to the combinational FFT core with a valid/ready handshake.
- Because lane k already holds sample bitrev5(k), the FFT core's din0..din31 connect straight to lanes 0..31.

---
 rtl/fft32_input_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fft32_input_loader.sv
// Ping-pong frame loader for the 32-point FFT: scatters serial samples into bit-reversed lanes.
// Optional build macro FFT32_LOADER_SCALE_EN pre-scales every sample by >>> SCALE_SHIFT.
module fft32_input_loader #(
    parameter int N           = 32,
    parameter int DW          = 32,
    parameter int SCALE_SHIFT = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] frame_data,
    output logic [5:0]      fill_level,
    output logic [15:0]     frame_count
);

    if (N != 32 || SCALE_SHIFT < 0 || SCALE_SHIFT >= DW) begin : g_bad_cfg
        $error("fft32_input_loader: N must be 32 and SCALE_SHIFT within 0..DW-1");
    end

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    logic [DW-1:0] mem_q [0:2*N-1];
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [4:0]    wr_cnt_q, wr_cnt_d;
    logic [1:0]    full_q, full_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          accept_s;
    logic          handoff_s;
    logic [5:0]    wr_addr_s;
    logic [DW-1:0] sample_s;

    assign in_ready    = rst_n & ~full_q[wr_bank_q];
    assign out_valid   = full_q[rd_bank_q];
    assign fill_level  = {1'b0, wr_cnt_q};
    assign frame_count = frame_count_q;
    assign accept_s    = in_valid & in_ready & ~flush;
    assign handoff_s   = full_q[rd_bank_q] & out_ready;
    assign wr_addr_s   = {wr_bank_q, bitrev5(wr_cnt_q)};

    // Sample conditioning ahead of the storage write
    always_comb begin
        sample_s = '0;
`ifdef FFT32_LOADER_SCALE_EN
        sample_s = DW'($signed(in_data) >>> SCALE_SHIFT);
`else
        sample_s = in_data;
`endif
    end

    // Next-state for write pointer, bank flags and handoff bookkeeping
    always_comb begin
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_cnt_d      = wr_cnt_q;
        full_d        = full_q;
        frame_count_d = frame_count_q;
        if (flush) begin
            wr_cnt_d = 5'd0;
        end else if (accept_s) begin
            if (wr_cnt_q == 5'd31) begin
                wr_cnt_d          = 5'd0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 5'd1;
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        // accept needs the write bank empty and handoff needs the read bank full, so they never collide
        if (handoff_s) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_count_d     = frame_count_q + 16'd1;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_cnt_q      <= 5'd0;
            full_q        <= 2'b00;
            frame_count_q <= 16'd0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            full_q        <= full_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Two-bank sample storage; bit-reversed scatter on write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2*N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept_s) begin
            mem_q[wr_addr_s] <= sample_s;
        end
    end

    // Parallel frame view of the read bank
    always_comb begin
        frame_data = '0;
        for (int k = 0; k < N; k++) begin
            frame_data[k*DW +: DW] = mem_q[{rd_bank_q, 5'(k)}];
        end
    end

endmodule
